cam_pixel_fifo: RTL and testbench
=================================

# cam_pixel_fifo

Single-clock capture-side buffer that packs the camera's two-byte RGB444 stream into 12-bit pixels and presents them first-word-fall-through to the HDMI pixel generator's `Mem_Read`/`Mem_Data` port. It sits directly upstream of the debug video output stage. Its input is the camera byte stream, already resynchronised to `clk`. Its outputs are the pixel stream plus sticky overflow/underflow status for the debug register block.

## Interface
- `DEPTH`, 1024: pixel storage depth; must be a power of two, ≥ 4.
- `AW`, log2(`DEPTH`): address width, derived.
- `clk`  in  1  system/pixel clock; all logic on rising edge.
- `rstn`  in  1  reset; asynchronous, active-low.
- `Cam_Data`  in  8  camera byte.
- `Cam_Valid`  in  1  `Cam_Data` valid this cycle.
- `Cam_Href`  in  1  line active (byte pairing window).
- `Cam_Vsync`  in  1  frame sync, active-high.
- `Mem_Read`  in  1  consumer pops current pixel at this edge.
- `Mem_Data`  out  12  current head pixel {R[3:0],G[3:0],B[3:0]}; 12'h000 when empty.
- `Mem_Empty`  out  1  no pixel at head.
- `Mem_Full`  out  1  `Fill_Level` == `DEPTH`.
- `Fill_Level`  out  AW+1  pixels stored.
- `Overflow`  out  1  sticky: a pixel was dropped.
- `Underflow`  out  1  sticky: `Mem_Read` while empty.
- `Clr_Status`  in  1  pulse clears `Overflow`/`Underflow`.

## Operation
- Byte packer: `phase` register, 0/1. Cleared whenever `Cam_Href`=0 or `Cam_Vsync`=1.
- On `Cam_Valid && Cam_Href`:
  - phase 0: latch `Cam_Data[3:0]` as R; phase becomes 1.
  - phase 1: form pixel {R, `Cam_Data[7:4]`, `Cam_Data[3:0]`}, issue push, phase becomes 0.
- A lone phase-0 byte at `Cam_Href` fall is discarded.
- Flush: detect `Cam_Vsync` rising edge using a registered copy of `Cam_Vsync`, reset value 0. The detect cycle resets both pointers, `Fill_Level` and phase. Flush overrides any push/pop in that cycle. Sticky flags are not affected.
- Push: accepted if `!Mem_Full`, or if a valid pop occurs in the same cycle. Otherwise the pixel is dropped and `Overflow` is set.
- Pop: `Mem_Read && !Mem_Empty` advances the head. `Mem_Read && Mem_Empty` sets `Underflow` and changes no state.
- Status clearing: if `Clr_Status` and a set condition occur in the same cycle, set wins.
- Storage: circular RAM with `AW`-bit read/write pointers that wrap modulo `DEPTH`. `Fill_Level` is an explicit counter: +1 push only, −1 pop only, unchanged for both or neither.
- FWFT head: `Mem_Data` comes from an output register loaded from RAM at the read pointer. The head word counts in `Fill_Level`.
- Pixel order is preserved; nothing is reordered or duplicated.

## Timing
- Reset values: `Mem_Data`=0, `Mem_Empty`=1, `Mem_Full`=0, `Fill_Level`=0, `Overflow`=0, `Underflow`=0, phase=0.
- Second camera byte at edge N: the push is registered at edge N.
- Push at edge N into an empty buffer: `Mem_Empty` falls and `Mem_Data` is valid after edge N+1.
- Pop at edge M with ≥2 pixels stored: the next pixel is on `Mem_Data` after edge M. Back-to-back pops sustain one pixel per clock, with no bubble.
- Pop of the last pixel: `Mem_Empty`=1 and `Mem_Data`=0 after edge M.
- Empty buffer with simultaneous push and `Mem_Read`: `Underflow` is set and the push is kept.
- `Mem_Full`, `Overflow` and `Underflow` update at the same edge as the causing event.
- Reset asserted mid-line: all state returns to reset values immediately. The first pixel after reset requires a fresh byte pair.

## Structure
- Shared package `cam_pkg`:
  - `PIX_W`=12.
  - RGB444 field positions: R [11:8], G [7:4], B [3:0].
  - `CAM_BYTE_W`=8.
  - These are shared with the HDMI stage.
- Sub-module `cam_byte_packer`: phase, R latch, push strobe and Vsync edge detect.
- The FIFO core (RAM, pointers, fill counter, output register) stays in `cam_pixel_fifo`.

## Test plan
- Byte packing: bytes 0x0A, 0xBC with `Href` high, followed by one `Mem_Read` → `Mem_Data`=12'hABC two edges after the second byte; `Fill_Level` 1 then 0.
- Sustained reading: 640 pixels written, then `Mem_Read` held for 640 cycles → values stream in order, one per clock; `Mem_Empty`=1 after the last; `Underflow`=0.
- Overflow: `DEPTH`+3 pixels pushed with no reads → `Mem_Full`=1, `Fill_Level`=1024, `Overflow`=1; the first 1024 pixels read back intact. `Clr_Status` then clears `Overflow`.
- Push on full with pop: full buffer, push and pop in the same cycle → `Fill_Level` stays 1024, `Overflow`=0, the new pixel is last out.
- Underflow: `Mem_Read` on an empty buffer → `Underflow`=1, `Mem_Data`=0, pointers unchanged.
- Flush and resync: `Vsync` rises with 100 pixels stored → `Fill_Level`=0 and `Mem_Empty`=1 next cycle. A lone byte before `Href` fall is discarded and does not corrupt the next line's first pixel.

Source files
------------

// File: rtl/cam_pkg.sv
// Pixel and camera-byte definitions shared by the capture FIFO and the HDMI stage.
// RGB444 pixels are {R,G,B} nibbles, most significant nibble first.
package cam_pkg;

   localparam int PIX_W      = 12;
   localparam int CAM_BYTE_W = 8;
   localparam int NIB_W      = 4;

   localparam int R_LSB = 8;
   localparam int G_LSB = 4;
   localparam int B_LSB = 0;

   typedef logic [PIX_W-1:0] pixel_t;
   typedef logic [NIB_W-1:0] nibble_t;

   function automatic pixel_t pack_rgb(input nibble_t r, input nibble_t g, input nibble_t b);
      pixel_t p;
      p = '0;
      p[R_LSB +: NIB_W] = r;
      p[G_LSB +: NIB_W] = g;
      p[B_LSB +: NIB_W] = b;
      return p;
   endfunction

endpackage

// File: rtl/cam_pixel_fifo_if.sv
// Camera byte input, FWFT pixel output and sticky status of the capture FIFO.
// The FIFO uses the slave modport; the camera front end / pixel generator use master.
interface cam_pixel_fifo_if #(
   parameter int DEPTH = 1024
);
   import cam_pkg::*;

   localparam int AW = $clog2(DEPTH);

   logic [CAM_BYTE_W-1:0] Cam_Data;
   logic                  Cam_Valid;
   logic                  Cam_Href;
   logic                  Cam_Vsync;
   logic                  Mem_Read;
   logic                  Clr_Status;
   logic [PIX_W-1:0]      Mem_Data;
   logic                  Mem_Empty;
   logic                  Mem_Full;
   logic [AW:0]           Fill_Level;
   logic                  Overflow;
   logic                  Underflow;

   modport slave (
      input  Cam_Data, Cam_Valid, Cam_Href, Cam_Vsync, Mem_Read, Clr_Status,
      output Mem_Data, Mem_Empty, Mem_Full, Fill_Level, Overflow, Underflow
   );

   modport master (
      output Cam_Data, Cam_Valid, Cam_Href, Cam_Vsync, Mem_Read, Clr_Status,
      input  Mem_Data, Mem_Empty, Mem_Full, Fill_Level, Overflow, Underflow
   );

endinterface

// File: rtl/cam_byte_packer.sv
// Pairs camera bytes into RGB444 pixels and flags the Vsync rising edge.
// push/flush are combinational so the FIFO acts on them at the edge of the second byte.
module cam_byte_packer
   import cam_pkg::*;
(
   input  logic                  clk,
   input  logic                  rstn,
   input  logic [CAM_BYTE_W-1:0] cam_data,
   input  logic                  cam_valid,
   input  logic                  cam_href,
   input  logic                  cam_vsync,
   output logic                  push,
   output pixel_t                push_pix,
   output logic                  flush
);

   logic    phase_q, phase_d;
   nibble_t r_q, r_d;
   logic    vsync_q, vsync_d;

   always_comb begin
      phase_d  = phase_q;
      r_d      = r_q;
      vsync_d  = cam_vsync;
      push     = 1'b0;
      push_pix = pack_rgb(r_q, cam_data[7:4], cam_data[3:0]);
      flush    = cam_vsync && !vsync_q;
      // Outside an active line a half-received pixel is abandoned.
      if (!cam_href || cam_vsync) begin
         phase_d = 1'b0;
      end else if (cam_valid) begin
         if (!phase_q) begin
            r_d     = cam_data[3:0];
            phase_d = 1'b1;
         end else begin
            push    = 1'b1;
            phase_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         phase_q <= 1'b0;
         r_q     <= '0;
         vsync_q <= 1'b0;
      end else begin
         phase_q <= phase_d;
         r_q     <= r_d;
         vsync_q <= vsync_d;
      end
   end

endmodule

// File: rtl/cam_pixel_fifo.sv
// Capture-side pixel FIFO: circular RAM plus a first-word-fall-through head register.
// The head word is part of Fill_Level; Mem_Empty reflects whether the head register is loaded.
module cam_pixel_fifo
   import cam_pkg::*;
#(
   parameter int DEPTH = 1024
) (
   input  logic             clk,
   input  logic             rstn,
   cam_pixel_fifo_if.slave  bus
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);
   localparam logic [AW:0] TWO_LVL  = (AW+1)'(2);

   logic   push;
   logic   flush;
   pixel_t push_pix;

   cam_byte_packer u_packer (
      .clk       (clk),
      .rstn      (rstn),
      .cam_data  (bus.Cam_Data),
      .cam_valid (bus.Cam_Valid),
      .cam_href  (bus.Cam_Href),
      .cam_vsync (bus.Cam_Vsync),
      .push      (push),
      .push_pix  (push_pix),
      .flush     (flush)
   );

   pixel_t          ram_q [DEPTH];
   logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [AW:0]     fill_q, fill_d;
   pixel_t          head_q, head_d;
   logic            head_vld_q, head_vld_d;
   logic            ovf_q, ovf_d;
   logic            unf_q, unf_d;

   logic            full;
   logic            pop;
   logic            push_ok;
   logic            ram_we;

   always_comb begin
      full    = (fill_q == FULL_LVL);
      pop     = bus.Mem_Read && head_vld_q;
      push_ok = push && (!full || pop);
      ram_we  = push_ok && !flush;

      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      fill_d     = fill_q;
      head_d     = head_q;
      head_vld_d = head_vld_q;

      // Set beats clear; a flush cycle neither sets nor masks a pending clear.
      ovf_d = (ovf_q && !bus.Clr_Status) || (push && !push_ok && !flush);
      unf_d = (unf_q && !bus.Clr_Status) || (bus.Mem_Read && !head_vld_q && !flush);

      if (flush) begin
         wr_ptr_d   = '0;
         rd_ptr_d   = '0;
         fill_d     = '0;
         head_d     = '0;
         head_vld_d = 1'b0;
      end else begin
         if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
         if (pop)     rd_ptr_d = rd_ptr_q + AW'(1);
         case ({push_ok, pop})
            2'b10:   fill_d = fill_q + (AW+1)'(1);
            2'b01:   fill_d = fill_q - (AW+1)'(1);
            default: fill_d = fill_q;
         endcase
         // A pop prefetches the word behind the head so back-to-back reads never stall;
         // a word written into an empty buffer reaches the head one edge later.
         if (pop) begin
            if (fill_q >= TWO_LVL) begin
               head_d     = ram_q[rd_ptr_q + AW'(1)];
               head_vld_d = 1'b1;
            end else begin
               head_d     = '0;
               head_vld_d = 1'b0;
            end
         end else if (!head_vld_q && fill_q != '0) begin
            head_d     = ram_q[rd_ptr_q];
            head_vld_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (ram_we) ram_q[wr_ptr_q] <= push_pix;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         fill_q     <= '0;
         head_q     <= '0;
         head_vld_q <= 1'b0;
         ovf_q      <= 1'b0;
         unf_q      <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         fill_q     <= fill_d;
         head_q     <= head_d;
         head_vld_q <= head_vld_d;
         ovf_q      <= ovf_d;
         unf_q      <= unf_d;
      end
   end

   assign bus.Mem_Data   = head_q;
   assign bus.Mem_Empty  = !head_vld_q;
   assign bus.Mem_Full   = full;
   assign bus.Fill_Level = fill_q;
   assign bus.Overflow   = ovf_q;
   assign bus.Underflow  = unf_q;

endmodule

// File: tb/tb_cam_pixel_fifo.sv
// Directed bench for cam_pixel_fifo: queue-based reference model compared every cycle,
// plus hand-computed expectations at the key points of each scenario.
module tb_cam_pixel_fifo;
   import cam_pkg::*;

   localparam int DEPTH = 1024;

   logic clk  = 1'b0;
   logic rstn = 1'b0;
   always #5 clk = ~clk;

   cam_pixel_fifo_if #(.DEPTH(DEPTH)) bus ();

   cam_pixel_fifo #(.DEPTH(DEPTH)) dut (
      .clk  (clk),
      .rstn (rstn),
      .bus  (bus)
   );

   int checks = 0;
   int errors = 0;
   bit chk_en = 1'b0;

   // Reference model: stored pixels in order, each stamped with the edge it arrived at.
   typedef struct {
      logic [11:0] pix;
      int          arr;
   } ent_t;

   ent_t        mq[$];
   int          now     = 0;
   bit          m_phase = 1'b0;
   logic [3:0]  m_r     = 4'h0;
   bit          m_vsp   = 1'b0;
   bit          m_ov    = 1'b0;
   bit          m_un    = 1'b0;

   // The head is presented once it has been stored for at least one full edge.
   function automatic bit m_vis();
      return (mq.size() > 0) && (mq[0].arr < now);
   endfunction

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
      end
   endtask

   task automatic model_step();
      bit          vis, vrise, mpush, mpop, acc, ov_set, un_set;
      logic [11:0] pix;
      if (!rstn) begin
         mq.delete();
         now = 0; m_phase = 1'b0; m_r = 4'h0; m_vsp = 1'b0; m_ov = 1'b0; m_un = 1'b0;
         return;
      end
      vis   = m_vis();
      vrise = bus.Cam_Vsync && !m_vsp;
      m_vsp = bus.Cam_Vsync;
      now++;
      if (vrise) begin
         mq.delete();
         m_phase = 1'b0;
         if (bus.Clr_Status) begin m_ov = 1'b0; m_un = 1'b0; end
         return;
      end
      mpush  = bus.Cam_Valid && bus.Cam_Href && !bus.Cam_Vsync && m_phase;
      pix    = {m_r, bus.Cam_Data};
      mpop   = bus.Mem_Read && vis;
      acc    = mpush && ((mq.size() < DEPTH) || mpop);
      ov_set = mpush && !acc;
      un_set = bus.Mem_Read && !vis;
      m_ov   = (m_ov && !bus.Clr_Status) || ov_set;
      m_un   = (m_un && !bus.Clr_Status) || un_set;
      if (mpop) void'(mq.pop_front());
      if (acc) mq.push_back('{pix, now});
      if (!bus.Cam_Href || bus.Cam_Vsync) m_phase = 1'b0;
      else if (bus.Cam_Valid) begin
         if (!m_phase) m_r = bus.Cam_Data[3:0];
         m_phase = !m_phase;
      end
   endtask

   task automatic compare();
      logic [11:0] exp_data;
      exp_data = m_vis() ? mq[0].pix : 12'h000;
      check("mem_data",   32'(bus.Mem_Data),   32'(exp_data));
      check("mem_empty",  32'(bus.Mem_Empty),  32'(!m_vis()));
      check("mem_full",   32'(bus.Mem_Full),   32'(mq.size() == DEPTH));
      check("fill_level", 32'(bus.Fill_Level), 32'(mq.size()));
      check("overflow",   32'(bus.Overflow),   32'(m_ov));
      check("underflow",  32'(bus.Underflow),  32'(m_un));
   endtask

   initial forever begin
      @(posedge clk);
      model_step();
   end

   initial forever begin
      @(negedge clk);
      if (chk_en && rstn) compare();
   end

   task automatic step(input bit v, input logic [7:0] d, input bit rd);
      bus.Cam_Valid = v;
      bus.Cam_Data  = d;
      bus.Mem_Read  = rd;
      @(negedge clk);
   endtask

   task automatic push_pix(input logic [11:0] p, input bit rd_on_second);
      logic [7:0] b0;
      b0 = {4'h0, p[11:8]};
      step(1'b1, b0, 1'b0);
      step(1'b1, p[7:0], rd_on_second);
   endtask

   task automatic idle(input int n);
      repeat (n) step(1'b0, 8'h00, 1'b0);
   endtask

   task automatic reads(input int n);
      repeat (n) step(1'b0, 8'h00, 1'b1);
   endtask

   task automatic clear_status();
      bus.Clr_Status = 1'b1;
      idle(1);
      bus.Clr_Status = 1'b0;
   endtask

   initial begin
      bus.Cam_Data   = '0;
      bus.Cam_Valid  = 1'b0;
      bus.Cam_Href   = 1'b0;
      bus.Cam_Vsync  = 1'b0;
      bus.Mem_Read   = 1'b0;
      bus.Clr_Status = 1'b0;
      rstn = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_data",  32'(bus.Mem_Data),   32'h000);
      check("rst_empty", 32'(bus.Mem_Empty),  32'd1);
      check("rst_full",  32'(bus.Mem_Full),   32'd0);
      check("rst_fill",  32'(bus.Fill_Level), 32'd0);
      check("rst_ovf",   32'(bus.Overflow),   32'd0);
      check("rst_unf",   32'(bus.Underflow),  32'd0);
      rstn   = 1'b1;
      chk_en = 1'b1;
      idle(1);

      // Byte packing: 0x0A, 0xBC -> 12'hABC
      bus.Cam_Href = 1'b1;
      step(1'b1, 8'h0A, 1'b0);
      step(1'b1, 8'hBC, 1'b0);
      check("pack_fill_n",   32'(bus.Fill_Level), 32'd1);
      check("pack_empty_n",  32'(bus.Mem_Empty),  32'd1);
      idle(1);
      check("pack_data",     32'(bus.Mem_Data),   32'hABC);
      check("pack_empty_n1", 32'(bus.Mem_Empty),  32'd0);
      reads(1);
      check("pack_fill_pop", 32'(bus.Fill_Level), 32'd0);
      check("pack_empty_pop",32'(bus.Mem_Empty),  32'd1);
      idle(1);

      // Sustained reading of 640 pixels
      for (int i = 0; i < 640; i++) push_pix(12'(i * 37 + 5), 1'b0);
      idle(1);
      check("stream_fill",  32'(bus.Fill_Level), 32'd640);
      check("stream_first", 32'(bus.Mem_Data),   32'h005);
      reads(1);
      check("stream_second", 32'(bus.Mem_Data),  32'h02A);
      reads(639);
      idle(1);
      check("stream_empty", 32'(bus.Mem_Empty),  32'd1);
      check("stream_unf",   32'(bus.Underflow),  32'd0);

      // Overflow: DEPTH+3 pushes without reads
      for (int i = 0; i < DEPTH + 3; i++) push_pix(12'(i * 5 + 1), 1'b0);
      idle(1);
      check("ovf_full",  32'(bus.Mem_Full),   32'd1);
      check("ovf_fill",  32'(bus.Fill_Level), 32'd1024);
      check("ovf_flag",  32'(bus.Overflow),   32'd1);
      check("ovf_head",  32'(bus.Mem_Data),   32'h001);
      reads(DEPTH);
      idle(1);
      check("ovf_drained", 32'(bus.Mem_Empty), 32'd1);
      clear_status();
      check("ovf_clr",   32'(bus.Overflow),   32'd0);

      // Push on full with simultaneous pop
      for (int i = 0; i < DEPTH; i++) push_pix(12'(i * 3), 1'b0);
      idle(1);
      check("pf_full",   32'(bus.Mem_Full),   32'd1);
      step(1'b1, 8'h05, 1'b0);
      step(1'b1, 8'hA5, 1'b1);
      check("pf_fill",   32'(bus.Fill_Level), 32'd1024);
      check("pf_ovf",    32'(bus.Overflow),   32'd0);
      check("pf_head",   32'(bus.Mem_Data),   32'h003);
      reads(DEPTH - 1);
      check("pf_last",   32'(bus.Mem_Data),   32'h5A5);
      check("pf_last_fill", 32'(bus.Fill_Level), 32'd1);
      reads(1);
      idle(1);

      // Underflow on empty, set-wins, then push+read on empty
      reads(1);
      check("unf_flag",  32'(bus.Underflow),  32'd1);
      check("unf_data",  32'(bus.Mem_Data),   32'h000);
      check("unf_fill",  32'(bus.Fill_Level), 32'd0);
      bus.Clr_Status = 1'b1;
      reads(1);
      bus.Clr_Status = 1'b0;
      check("unf_set_wins", 32'(bus.Underflow), 32'd1);
      clear_status();
      check("unf_clr",   32'(bus.Underflow),  32'd0);
      step(1'b1, 8'h03, 1'b0);
      step(1'b1, 8'h21, 1'b1);
      check("unf_push_flag", 32'(bus.Underflow),  32'd1);
      check("unf_push_fill", 32'(bus.Fill_Level), 32'd1);
      idle(1);
      check("unf_push_data", 32'(bus.Mem_Data),   32'h321);
      reads(1);
      clear_status();

      // Flush on Vsync rise, then a lone byte before Href fall
      for (int i = 0; i < 100; i++) push_pix(12'(i + 256), 1'b0);
      check("fl_fill_pre", 32'(bus.Fill_Level), 32'd100);
      bus.Cam_Vsync = 1'b1;
      idle(1);
      check("fl_fill",  32'(bus.Fill_Level), 32'd0);
      check("fl_empty", 32'(bus.Mem_Empty),  32'd1);
      idle(1);
      bus.Cam_Vsync = 1'b0;
      step(1'b1, 8'h0F, 1'b0);
      bus.Cam_Href = 1'b0;
      idle(1);
      bus.Cam_Href = 1'b1;
      step(1'b1, 8'h01, 1'b0);
      step(1'b1, 8'h23, 1'b0);
      idle(1);
      check("resync_data", 32'(bus.Mem_Data),   32'h123);
      check("resync_fill", 32'(bus.Fill_Level), 32'd1);
      reads(1);

      // Reset asserted mid-line
      push_pix(12'h777, 1'b0);
      step(1'b1, 8'h0D, 1'b0);
      chk_en = 1'b0;
      #2 rstn = 1'b0;
      #1;
      check("mid_rst_fill",  32'(bus.Fill_Level), 32'd0);
      check("mid_rst_empty", 32'(bus.Mem_Empty),  32'd1);
      check("mid_rst_data",  32'(bus.Mem_Data),   32'h000);
      @(negedge clk);
      rstn   = 1'b1;
      chk_en = 1'b1;
      step(1'b1, 8'hEF, 1'b0);
      step(1'b1, 8'h12, 1'b0);
      idle(1);
      check("post_rst_data", 32'(bus.Mem_Data),   32'hF12);
      check("post_rst_fill", 32'(bus.Fill_Level), 32'd1);
      idle(2);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
